slow_memory_model: RTL and testbench
====================================

// Module: slow_memory_model
// PURPOSE
// - Behavioural multi-cycle line memory behind the I- and D-caches of CHIP; one instance per cache.
// - Serves whole 128-bit lines addressed by byte-address bits [31:4] with a fixed access latency.
// - Uses a request/ready handshake.
// - Array is preloadable by hierarchical $readmemh/$readmemb and is never cleared by reset.
// PARAMETERS
// - ADDR_W   28    line-address width (byte address bits 31:4)
// - DATA_W   128   line width in bits
// - DEPTH    1024  number of lines in array `mem`; index = mem_addr % DEPTH (wrap-around)
// - LATENCY  5     cycles from request acceptance to mem_ready (>=1)
// PORTS
// - clk        in   1       single clock, rising edge
// - rst_n      in   1       asynchronous active-low reset
// - mem_read   in   1       read request level, held until mem_ready
// - mem_write  in   1       write request level, held until mem_ready
// - mem_addr   in   ADDR_W  line address
// - mem_wdata  in   DATA_W  write line data
// - mem_rdata  out  DATA_W  read line data, valid while mem_ready=1
// - mem_ready  out  1       one-cycle completion pulse
// BEHAVIOUR
// - Storage: reg [DATA_W-1:0] mem [0:DEPTH-1], named exactly `mem`.
// - Reset: mem_ready=0, mem_rdata=0, state=IDLE, counter=0; `mem` contents untouched.
// - Reset asserted mid-access aborts the access: no write is committed and no ready pulse is issued.
// - FSM IDLE -> BUSY -> DONE -> IDLE.
// - IDLE: on an edge with mem_read|mem_write=1, latch op, addr and wdata, load counter=LATENCY-1.
//   - If LATENCY==1, go straight to DONE; otherwise go to BUSY.
// - BUSY: decrement counter each edge; when counter reaches 0, go to DONE.
// - DONE: mem_ready=1 for exactly one cycle.
//   - Read: mem_rdata=mem[idx] from the latched address.
//   - Write: mem[idx]<=latched wdata at the edge leaving DONE.
//   - Next state is IDLE unconditionally.
// - Latency: request seen at edge N gives mem_ready high in the cycle after edge N+LATENCY-1.
//   - That is, LATENCY cycles of ready=0 then ready=1; back-to-back requests are spaced LATENCY+1 cycles apart.
// - The requester drops or changes its request on the edge that samples ready.
//   - IDLE accepts a new request at the following edge.
// - Request inputs changing during BUSY are ignored; the latched values rule.
// - mem_read and mem_write both high: treat as a write (write priority); mem_rdata is left unchanged.
// - mem_rdata holds its last value outside DONE.
// - Read after write to the same line returns the new data.
// - Address is outside DEPTH: the index wraps modulo DEPTH; no error is flagged.
// STRUCTURE
// - Shared package mem_pkg: ADDR_W, DATA_W, state enum {IDLE, BUSY, DONE}.
// - Single flat module; counter and FSM are inline, no sub-module.
// TESTING
// - Reset low 8 cycles, then high -> mem_ready=0 and mem_rdata=0 throughout; a preloaded mem[3] survives.
// - Preload mem[2]=128'h0123..CDEF; mem_read=1, addr=2 -> ready high in cycle LATENCY+1 with rdata=preload.
// - Write addr=5, wdata=128'hDEADBEEF_...; then read addr=5 -> rdata=128'hDEADBEEF_...; no extra ready pulses.
// - Addr 5+DEPTH read -> returns mem[5] (wrap-around).
// - rst_n low in mid-BUSY of a write to addr 7 -> no ready pulse; mem[7] unchanged.
// - Read and write both high, addr 9 -> mem[9]=wdata; rdata unchanged.
// - Request held through ready and reissued -> second ready exactly LATENCY+1 cycles after the first.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the line memory model.
package mem_pkg;
  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;
endpackage

// File: rtl/slow_memory_model.sv
// Multi-cycle 128-bit line memory with a fixed access latency.
// The array is never cleared by reset so it can be preloaded.
module slow_memory_model #(
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int DATA_W  = mem_pkg::DATA_W,
  parameter int DEPTH   = mem_pkg::DEPTH,
  parameter int LATENCY = mem_pkg::LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready
);
  import mem_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;

  function automatic logic [IDX_W-1:0] to_idx(
    input logic [ADDR_W-1:0] a
  );
    return IDX_W'(a % ADDR_W'(DEPTH));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          wr_d    = mem_write;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = DONE;
            ready_d = 1'b1;
            if (!mem_write)
              rdata_d = mem[to_idx(mem_addr)];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter hits zero on this edge: enter DONE with data ready.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          ready_d = 1'b1;
          if (!wr_q)
            rdata_d = mem[to_idx(addr_q)];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  // Write commits on the edge leaving DONE; a reset before then aborts it.
  always_ff @(posedge clk) begin
    if (state_q == DONE && wr_q)
      mem[to_idx(addr_q)] <= wdata_q;
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
endmodule

// File: tb/tb_slow_memory_model.sv
// Randomised self-checking bench for slow_memory_model.
module tb_slow_memory_model;
  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int DEP = 1024;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] ref_rdata = '0;

  slow_memory_model #(
    .ADDR_W(AW), .DATA_W(DW),
    .DEPTH(DEP), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int ridx(input logic [AW-1:0] a);
    return int'(a % AW'(DEP));
  endfunction

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issue one request, check latency, one-cycle pulse and data.
  task automatic access(input logic rd, input logic wr,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] wd,
                        input string tag);
    int lat;
    logic [DW-1:0] got;
    @(negedge clk);
    mem_read = rd;
    mem_write = wr;
    mem_addr = a;
    mem_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!mem_ready && lat < 50);
    got = mem_rdata;
    mem_read = 1'b0;
    mem_write = 1'b0;
    chk({tag, "_lat"}, DW'(lat), DW'(LAT));
    if (wr) ref_mem[ridx(a)] = wd;
    else if (ref_mem.exists(ridx(a)))
      ref_rdata = ref_mem[ridx(a)];
    chk({tag, "_rdata"}, got, ref_rdata);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, DW'(mem_ready), DW'(0));
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) begin
        chk({tag, "_rdy"}, DW'(mem_ready), DW'(0));
        chk({tag, "_rd0"}, mem_rdata, '0);
      end
    end
    rst_n = 1'b1;
    ref_rdata = '0;
    @(posedge clk);
    #1;
    chk({tag, "_rdy_post"}, DW'(mem_ready), DW'(0));
  endtask

  initial begin : main
    logic [DW-1:0] pre2, pre3, pre7, dead, w9, old;
    int p1, cyc;
    bit seen;
    pre2 = 128'h0123456789ABCDEF0123456789ABCDEF;
    pre3 = 128'h33333333_CAFEF00D_33333333_0BADF00D;
    pre7 = 128'h77777777_77777777_12345678_9ABCDEF0;
    dead = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    w9   = 128'h99999999_ABABABAB_99999999_CDCDCDCD;

    reset_pulse("rst0");
    access(1'b0, 1'b1, AW'(3), pre3, "pre3");
    reset_pulse("rst1");
    access(1'b1, 1'b0, AW'(3), '0, "rd3_survive");

    access(1'b0, 1'b1, AW'(2), pre2, "pre2");
    access(1'b1, 1'b0, AW'(2), '0, "rd2");
    access(1'b0, 1'b1, AW'(5), dead, "wr5");
    access(1'b1, 1'b0, AW'(5), '0, "rd5");
    access(1'b1, 1'b0, AW'(5 + DEP), '0, "rd5_wrap");

    // Abort a write to line 7 with reset while it is in flight.
    access(1'b0, 1'b1, AW'(7), pre7, "pre7");
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr = AW'(7);
    mem_wdata = rnd_line();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3 + LAT; i++) begin
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
      if (i == 1) begin
        mem_write = 1'b0;
        rst_n = 1'b1;
      end
    end
    chk("abort_no_ready", DW'(seen), DW'(0));
    ref_rdata = '0;
    access(1'b1, 1'b0, AW'(7), '0, "rd7_abort");

    // Both strobes high is a write and leaves read data alone.
    old = ref_rdata;
    access(1'b1, 1'b1, AW'(9), w9, "both9");
    chk("both9_rdata_hold", mem_rdata, old);
    access(1'b1, 1'b0, AW'(9), '0, "rd9");

    // Request held through ready: next ready LAT+1 cycles later.
    @(negedge clk);
    mem_read = 1'b1;
    mem_addr = AW'(2);
    cyc = 0;
    p1 = -1;
    seen = 1'b0;
    while (cyc < 60 && !seen) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_ready) begin
        if (p1 < 0) p1 = cyc;
        else begin
          seen = 1'b1;
          chk("b2b_gap", DW'(cyc - p1), DW'(LAT + 1));
          chk("b2b_rdata", mem_rdata, ref_mem[2]);
        end
      end
    end
    mem_read = 1'b0;
    if (!seen) chk("b2b_timeout", DW'(0), DW'(1));
    ref_rdata = ref_mem[2];
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Randomised traffic over wrapped aliases of 16 lines.
    for (int i = 0; i < 16; i++)
      access(1'b0, 1'b1, AW'(i), rnd_line(), "init");
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic r, w;
      a = AW'($urandom_range(0, 15))
        + AW'(DEP) * AW'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      access(r, w, a, rnd_line(), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
